// File: rtl/proc_wb_queue_if.sv
// Writeback queue bus: producer handshakes, RF write port and bypass lookup.
// master = environment side, slave = the queue itself.
interface proc_wb_queue_if #(
  parameter int XLEN   = 64,
  parameter int ADDR_W = 5
);
  logic              alu_valid;
  logic [ADDR_W-1:0] alu_rd;
  logic [XLEN-1:0]   alu_data;
  logic              alu_ready;

  logic              mem_valid;
  logic [ADDR_W-1:0] mem_rd;
  logic [XLEN-1:0]   mem_data;
  logic              mem_ready;

  logic              wb_hold;
  logic              rf_reg_write;
  logic [ADDR_W-1:0] rf_rd;
  logic [XLEN-1:0]   rf_wdata;

  logic [ADDR_W-1:0] byp_rs1;
  logic              byp_hit1;
  logic [XLEN-1:0]   byp_data1;
  logic [ADDR_W-1:0] byp_rs2;
  logic              byp_hit2;
  logic [XLEN-1:0]   byp_data2;

  logic              empty;
  logic              full;

  modport master (
    output alu_valid, alu_rd, alu_data,
    output mem_valid, mem_rd, mem_data,
    output wb_hold, byp_rs1, byp_rs2,
    input  alu_ready, mem_ready,
    input  rf_reg_write, rf_rd, rf_wdata,
    input  byp_hit1, byp_data1, byp_hit2, byp_data2,
    input  empty, full
  );

  modport slave (
    input  alu_valid, alu_rd, alu_data,
    input  mem_valid, mem_rd, mem_data,
    input  wb_hold, byp_rs1, byp_rs2,
    output alu_ready, mem_ready,
    output rf_reg_write, rf_rd, rf_wdata,
    output byp_hit1, byp_data1, byp_hit2, byp_data2,
    output empty, full
  );
endinterface

// File: rtl/proc_wb_queue.sv
// In-order writeback queue in front of the register file write port,
// with load-over-ALU arbitration and a two-port youngest-match bypass.
module proc_wb_queue #(
  parameter int XLEN   = 64,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 4
) (
  input  logic            clk,
  input  logic            rst,
  proc_wb_queue_if.slave  bus
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0] rd_mem   [DEPTH];
  logic [XLEN-1:0]   data_mem [DEPTH];
  logic [PTR_W-1:0]  head;
  logic [PTR_W-1:0]  tail;
  logic [CNT_W-1:0]  count;

  logic              pop;
  logic              space;
  logic              mem_ready;
  logic              alu_ready;
  logic              mem_fire;
  logic              alu_fire;
  logic              push;
  logic [ADDR_W-1:0] enq_rd;
  logic [XLEN-1:0]   enq_data;

  // A pop frees a slot in the same cycle, so a full queue can still accept.
  always_comb begin
    pop       = !rst && !bus.wb_hold && (count != '0);
    space     = (count < CNT_W'(DEPTH)) || pop;
    mem_ready = space && !rst;
    alu_ready = space && !rst && !bus.mem_valid;
    mem_fire  = bus.mem_valid && mem_ready;
    alu_fire  = bus.alu_valid && alu_ready;
  end

  // x0 results complete their handshake but are dropped here.
  always_comb begin
    enq_rd   = mem_fire ? bus.mem_rd   : bus.alu_rd;
    enq_data = mem_fire ? bus.mem_data : bus.alu_data;
    push     = (mem_fire || alu_fire) && (enq_rd != '0);
  end

  always_comb begin
    bus.mem_ready    = mem_ready;
    bus.alu_ready    = alu_ready;
    bus.rf_reg_write = pop;
    bus.rf_rd        = pop ? rd_mem[head]   : '0;
    bus.rf_wdata     = pop ? data_mem[head] : '0;
    bus.empty        = rst || (count == '0);
    bus.full         = !rst && (count == CNT_W'(DEPTH));
  end

  // Walk oldest to youngest so the youngest matching entry is the one kept.
  always_comb begin
    logic [PTR_W-1:0] idx;
    idx           = '0;
    bus.byp_hit1  = 1'b0;
    bus.byp_data1 = '0;
    bus.byp_hit2  = 1'b0;
    bus.byp_data2 = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + PTR_W'(i);
      if (!rst && (CNT_W'(i) < count)) begin
        if ((bus.byp_rs1 != '0) && (rd_mem[idx] == bus.byp_rs1)) begin
          bus.byp_hit1  = 1'b1;
          bus.byp_data1 = data_mem[idx];
        end
        if ((bus.byp_rs2 != '0) && (rd_mem[idx] == bus.byp_rs2)) begin
          bus.byp_hit2  = 1'b1;
          bus.byp_data2 = data_mem[idx];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      rd_mem[tail]   <= enq_rd;
      data_mem[tail] <= enq_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + PTR_W'(1);
      if (pop)  head <= head + PTR_W'(1);
      if (push && !pop)
        count <= count + CNT_W'(1);
      else if (pop && !push)
        count <= count - CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_proc_wb_queue.sv
// Self-checking bench for proc_wb_queue: directed scenarios with literal
// expectations plus randomized traffic against a queue-based reference model.
module tb_proc_wb_queue;
  localparam int XLEN   = 64;
  localparam int ADDR_W = 5;
  localparam int DEPTH  = 4;
  localparam int EW     = ADDR_W + XLEN;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  proc_wb_queue_if #(.XLEN(XLEN), .ADDR_W(ADDR_W)) bus_if ();

  proc_wb_queue #(.XLEN(XLEN), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  int vectors     = 0;
  int miscompares = 0;

  logic [EW-1:0] model_q [$];

  task automatic checkOutput(input string name, input logic [XLEN-1:0] act,
                             input logic [XLEN-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the pending writes are a plain FIFO of {rd,data}.
  always @(negedge clk) begin : model_check
    int               sz;
    logic             e_pop;
    logic             e_space;
    logic             e_mready;
    logic             e_aready;
    logic [EW-1:0]    entry;
    logic [ADDR_W-1:0] e_rd;
    logic [XLEN-1:0]  e_wdata;
    logic             e_hit1;
    logic             e_hit2;
    logic [XLEN-1:0]  e_data1;
    logic [XLEN-1:0]  e_data2;

    sz       = model_q.size();
    e_pop    = !rst && !bus_if.wb_hold && (sz != 0);
    e_space  = (sz < DEPTH) || e_pop;
    e_mready = !rst && e_space;
    e_aready = !rst && e_space && !bus_if.mem_valid;
    e_rd     = '0;
    e_wdata  = '0;
    if (e_pop) begin
      entry   = model_q[0];
      e_rd    = entry[EW-1:XLEN];
      e_wdata = entry[XLEN-1:0];
    end
    e_hit1  = 1'b0;
    e_hit2  = 1'b0;
    e_data1 = '0;
    e_data2 = '0;
    if (!rst) begin
      for (int i = 0; i < sz; i++) begin
        entry = model_q[i];
        if (bus_if.byp_rs1 != '0 && entry[EW-1:XLEN] == bus_if.byp_rs1) begin
          e_hit1  = 1'b1;
          e_data1 = entry[XLEN-1:0];
        end
        if (bus_if.byp_rs2 != '0 && entry[EW-1:XLEN] == bus_if.byp_rs2) begin
          e_hit2  = 1'b1;
          e_data2 = entry[XLEN-1:0];
        end
      end
    end

    checkOutput("mem_ready",    64'(bus_if.mem_ready),    64'(e_mready));
    checkOutput("alu_ready",    64'(bus_if.alu_ready),    64'(e_aready));
    checkOutput("rf_reg_write", 64'(bus_if.rf_reg_write), 64'(e_pop));
    checkOutput("rf_rd",        64'(bus_if.rf_rd),        64'(e_rd));
    checkOutput("rf_wdata",     bus_if.rf_wdata,          e_wdata);
    checkOutput("byp_hit1",     64'(bus_if.byp_hit1),     64'(e_hit1));
    checkOutput("byp_data1",    bus_if.byp_data1,         e_data1);
    checkOutput("byp_hit2",     64'(bus_if.byp_hit2),     64'(e_hit2));
    checkOutput("byp_data2",    bus_if.byp_data2,         e_data2);
    checkOutput("empty",        64'(bus_if.empty),        64'(rst || sz == 0));
    checkOutput("full",         64'(bus_if.full),         64'(!rst && sz == DEPTH));

    if (rst) begin
      model_q.delete();
    end else begin
      if (e_pop) void'(model_q.pop_front());
      if (bus_if.mem_valid && e_mready) begin
        if (bus_if.mem_rd != '0) model_q.push_back({bus_if.mem_rd, bus_if.mem_data});
      end else if (bus_if.alu_valid && e_aready && bus_if.alu_rd != '0) begin
        model_q.push_back({bus_if.alu_rd, bus_if.alu_data});
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic applyStimulus(input logic av, input int ard, input logic [XLEN-1:0] ad,
                               input logic mv, input int mrd, input logic [XLEN-1:0] md,
                               input logic hold);
    bus_if.alu_valid = av;
    bus_if.alu_rd    = ADDR_W'(ard);
    bus_if.alu_data  = ad;
    bus_if.mem_valid = mv;
    bus_if.mem_rd    = ADDR_W'(mrd);
    bus_if.mem_data  = md;
    bus_if.wb_hold   = hold;
  endtask

  task automatic idle(input int n);
    applyStimulus(0, 0, '0, 0, 0, '0, 0);
    bus_if.byp_rs1 = '0;
    bus_if.byp_rs2 = '0;
    repeat (n) next_cycle();
  endtask

  initial begin
    int   order [5];
    logic a_acc;
    logic m_acc;
    order = '{1, 2, 3, 4, 6};
    bus_if.byp_rs1 = '0;
    bus_if.byp_rs2 = '0;

    // Reset held with a load offered
    applyStimulus(0, 0, '0, 1, 5, 64'hAA, 0);
    repeat (2) begin
      sample();
      checkOutput("rst_we",     64'(bus_if.rf_reg_write), 64'd0);
      checkOutput("rst_mready", 64'(bus_if.mem_ready),    64'd0);
      checkOutput("rst_empty",  64'(bus_if.empty),        64'd1);
      next_cycle();
    end
    rst = 1'b0;
    sample();
    checkOutput("post_rst_mready", 64'(bus_if.mem_ready), 64'd1);
    next_cycle();
    bus_if.mem_valid = 1'b0;
    sample();
    checkOutput("post_rst_we",    64'(bus_if.rf_reg_write), 64'd1);
    checkOutput("post_rst_rd",    64'(bus_if.rf_rd),        64'd5);
    checkOutput("post_rst_wdata", bus_if.rf_wdata,          64'hAA);
    idle(2);

    // Arbitration: load wins, ALU follows
    applyStimulus(1, 3, 64'h33, 1, 4, 64'h44, 0);
    sample();
    checkOutput("arb_mready", 64'(bus_if.mem_ready), 64'd1);
    checkOutput("arb_aready", 64'(bus_if.alu_ready), 64'd0);
    next_cycle();
    bus_if.mem_valid = 1'b0;
    sample();
    checkOutput("arb_aready2", 64'(bus_if.alu_ready), 64'd1);
    checkOutput("arb_rd_x4",   64'(bus_if.rf_rd),     64'd4);
    next_cycle();
    bus_if.alu_valid = 1'b0;
    sample();
    checkOutput("arb_rd_x3",    64'(bus_if.rf_rd), 64'd3);
    checkOutput("arb_wdata_x3", bus_if.rf_wdata,   64'h33);
    idle(2);

    // Fill to full under hold, then pop+enqueue while full
    for (int r = 1; r <= 4; r++) begin
      applyStimulus(1, r, 64'(32'h100 + r), 0, 0, '0, 1);
      sample();
      checkOutput("fill_aready", 64'(bus_if.alu_ready), 64'd1);
      next_cycle();
    end
    applyStimulus(1, 6, 64'h106, 0, 0, '0, 1);
    sample();
    checkOutput("full_set",    64'(bus_if.full),      64'd1);
    checkOutput("full_aready", 64'(bus_if.alu_ready), 64'd0);
    next_cycle();
    bus_if.wb_hold = 1'b0;
    for (int k = 0; k < 5; k++) begin
      sample();
      checkOutput("drain_we", 64'(bus_if.rf_reg_write), 64'd1);
      checkOutput("drain_rd", 64'(bus_if.rf_rd),        64'(order[k]));
      if (k == 0) checkOutput("full_pop_aready", 64'(bus_if.alu_ready), 64'd1);
      if (k < 2)  checkOutput("full_keep",       64'(bus_if.full),      64'd1);
      next_cycle();
      if (k == 0) bus_if.alu_valid = 1'b0;
    end
    sample();
    checkOutput("drained_empty", 64'(bus_if.empty), 64'd1);
    idle(1);

    // Bypass: duplicate rd, youngest wins
    applyStimulus(1, 7, 64'h11, 0, 0, '0, 1);
    next_cycle();
    applyStimulus(1, 7, 64'h22, 0, 0, '0, 1);
    next_cycle();
    bus_if.alu_valid = 1'b0;
    bus_if.byp_rs1   = 5'd7;
    bus_if.byp_rs2   = 5'd9;
    sample();
    checkOutput("byp_hit1_x7",  64'(bus_if.byp_hit1), 64'd1);
    checkOutput("byp_data1_x7", bus_if.byp_data1,     64'h22);
    checkOutput("byp_hit2_x9",  64'(bus_if.byp_hit2), 64'd0);
    checkOutput("byp_data2_x9", bus_if.byp_data2,     64'd0);
    next_cycle();
    bus_if.byp_rs1 = '0;
    sample();
    checkOutput("byp_hit1_x0", 64'(bus_if.byp_hit1), 64'd0);
    next_cycle();
    bus_if.wb_hold = 1'b0;
    sample();
    checkOutput("byp_drain1", bus_if.rf_wdata, 64'h11);
    next_cycle();
    sample();
    checkOutput("byp_drain2", bus_if.rf_wdata, 64'h22);
    idle(2);

    // x0 result is accepted but dropped
    applyStimulus(1, 0, 64'hFF, 0, 0, '0, 0);
    sample();
    checkOutput("x0_aready", 64'(bus_if.alu_ready), 64'd1);
    next_cycle();
    bus_if.alu_valid = 1'b0;
    sample();
    checkOutput("x0_empty", 64'(bus_if.empty),        64'd1);
    checkOutput("x0_no_we", 64'(bus_if.rf_reg_write), 64'd0);
    idle(2);

    // Reset in the middle of a drain
    for (int r = 10; r <= 12; r++) begin
      applyStimulus(1, r, 64'(32'hA0 + r), 0, 0, '0, 1);
      next_cycle();
    end
    applyStimulus(0, 0, '0, 0, 0, '0, 0);
    sample();
    checkOutput("mid_rd_x10", 64'(bus_if.rf_rd), 64'd10);
    next_cycle();
    rst = 1'b1;
    sample();
    checkOutput("mid_rst_we",    64'(bus_if.rf_reg_write), 64'd0);
    checkOutput("mid_rst_empty", 64'(bus_if.empty),        64'd1);
    next_cycle();
    rst = 1'b0;
    repeat (3) begin
      sample();
      checkOutput("after_rst_empty", 64'(bus_if.empty),        64'd1);
      checkOutput("after_rst_we",    64'(bus_if.rf_reg_write), 64'd0);
      next_cycle();
    end

    // Randomized traffic; sources hold an offer until it is accepted
    a_acc = 1'b0;
    m_acc = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      rst            = ($urandom_range(0, 99) == 0);
      bus_if.wb_hold = ($urandom_range(0, 9) < 3);
      if (!bus_if.alu_valid || a_acc) begin
        bus_if.alu_valid = $urandom_range(0, 1) == 1;
        bus_if.alu_rd    = ADDR_W'($urandom_range(0, 7));
        bus_if.alu_data  = {$urandom, $urandom};
      end
      if (!bus_if.mem_valid || m_acc) begin
        bus_if.mem_valid = $urandom_range(0, 2) == 0;
        bus_if.mem_rd    = ADDR_W'($urandom_range(0, 7));
        bus_if.mem_data  = {$urandom, $urandom};
      end
      bus_if.byp_rs1 = ADDR_W'($urandom_range(0, 7));
      bus_if.byp_rs2 = ADDR_W'($urandom_range(0, 7));
      sample();
      a_acc = bus_if.alu_valid && bus_if.alu_ready;
      m_acc = bus_if.mem_valid && bus_if.mem_ready;
      next_cycle();
    end
    rst = 1'b0;
    idle(8);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
